// File: rtl/mc_sat_updown_counter.sv
// NCH-channel up/down saturating counter with per-channel step, load and shared bounds.
// Optional sticky ovf/unf flags are built only when MC_SAT_CNT_STICKY_EN is defined.
module mc_sat_updown_counter #(
  parameter int W   = 8,
  parameter int NCH = 4,
  parameter int SW  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W-1:0]      min_val,
  input  logic [W-1:0]      max_val,
  input  logic [NCH-1:0]    inc,
  input  logic [NCH-1:0]    dec,
  input  logic [NCH*SW-1:0] step,
  input  logic [NCH-1:0]    load,
  input  logic [NCH*W-1:0]  load_val,
  input  logic [NCH-1:0]    clr_sticky,
  output logic [NCH*W-1:0]  count,
  output logic [NCH-1:0]    at_max,
  output logic [NCH-1:0]    at_min,
  output logic [NCH-1:0]    ovf_sticky,
  output logic [NCH-1:0]    unf_sticky,
  output logic              cfg_err
);

  logic [NCH*W-1:0] count_q, count_d;
  logic [NCH-1:0]   at_max_q, at_max_d;
  logic [NCH-1:0]   at_min_q, at_min_d;
  logic [NCH-1:0]   ovf_ev, unf_ev;

  assign cfg_err = (min_val > max_val);

  always_comb begin
    logic [W-1:0]        cur, nxt, lv;
    logic [W:0]          stp, sum;
    logic signed [W:0]   diff;
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    count_d  = count_q;
    at_max_d = '0;
    at_min_d = '0;
    ovf_ev   = '0;
    unf_ev   = '0;
    for (int i = 0; i < NCH; i++) begin
      cur  = count_q[i*W +: W];
      lv   = load_val[i*W +: W];
      stp  = {{(W+1-SW){1'b0}}, step[i*SW +: SW]};
      sum  = {1'b0, cur} + stp;
      diff = $signed({1'b0, cur}) - $signed(stp);
      nxt  = cur;
      if (cfg_err) begin
        nxt = cur;
      end else if (load[i]) begin
        if (lv < min_val)      nxt = min_val;
        else if (lv > max_val) nxt = max_val;
        else                   nxt = lv;
      end else if (inc[i] && dec[i]) begin
        nxt = cur;
      end else if (inc[i] && (stp != '0)) begin
        if (sum > {1'b0, max_val}) begin
          nxt       = max_val;
          ovf_ev[i] = 1'b1;
        end else begin
          nxt = sum[W-1:0];
        end
      end else if (dec[i] && (stp != '0)) begin
        // Signed W+1 difference lets a borrow below zero compare as less than min_val.
        if (diff < $signed({1'b0, min_val})) begin
          nxt       = min_val;
          unf_ev[i] = 1'b1;
        end else begin
          nxt = diff[W-1:0];
        end
      end
      count_d[i*W +: W] = nxt;
      at_max_d[i]       = (nxt == max_val);
      at_min_d[i]       = (nxt == min_val);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      at_max_q <= '0;
      at_min_q <= '0;
    end else begin
      if (count_d != count_q) count_q <= count_d;
      at_max_q <= at_max_d;
      at_min_q <= at_min_d;
    end
  end

  assign count  = count_q;
  assign at_max = at_max_q;
  assign at_min = at_min_q;

`ifdef MC_SAT_CNT_STICKY_EN
  logic [NCH-1:0] ovf_sticky_q, unf_sticky_q;

  // A set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky_q <= '0;
      unf_sticky_q <= '0;
    end else begin
      ovf_sticky_q <= ovf_ev | (ovf_sticky_q & ~clr_sticky);
      unf_sticky_q <= unf_ev | (unf_sticky_q & ~clr_sticky);
    end
  end

  assign ovf_sticky = ovf_sticky_q;
  assign unf_sticky = unf_sticky_q;
`else
  logic unused_sticky;
  assign unused_sticky = ^{clr_sticky, ovf_ev, unf_ev};
  assign ovf_sticky    = '0;
  assign unf_sticky    = '0;
`endif

endmodule
